pc_ctrl: RTL
============

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter: CPU_WIDTH, 32, PC and target width in bits.
REQ-002 Parameter: RST_PC, 32'h0000_0000, boot address the PC register loads on reset; used only for the pending-target reset value.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena_i  input  1  system enable from PC register; 0 holds controller in BOOT.
REQ-006 curr_pc_i  input  CPU_WIDTH  current PC from PC register.
REQ-007 trap_req_i / trap_vec_i  input  1 / CPU_WIDTH  exception or interrupt redirect and its vector.
REQ-008 mret_req_i / mepc_i  input  1 / CPU_WIDTH  trap return and its target.
REQ-009 ex_redir_i / ex_target_i  input  1 / CPU_WIDTH  taken branch/jump from EX and its target.
REQ-010 load_use_i  input  1  load-use hazard stall request.
REQ-011 muldiv_busy_i  input  1  multi-cycle mul/div busy stall request.
REQ-012 ifetch_ready_i  input  1  instruction fetch can accept a new PC.
REQ-013 next_pc_o  output  CPU_WIDTH  next PC to PC register (combinational).
REQ-014 pipeline_stall_o  output  1  freeze PC register and IF/ID (combinational).
REQ-015 flush_o  output  1  kill IF/ID and ID/EX contents this cycle (combinational).
REQ-016 state_o  output  2  FSM state: 00 BOOT, 01 RUN, 10 HOLD, 11 PEND.

Function
REQ-017 Redirect R = trap_req_i | mret_req_i | ex_redir_i; target priority trap_vec_i > mepc_i > ex_target_i; target bits [1:0] forced to 00.
REQ-018 Stall source S = load_use_i | muldiv_busy_i | ~ifetch_ready_i.
REQ-019 BOOT: stall=1, flush=0, next_pc=curr_pc_i; all requests ignored; ena_i=1 -> RUN next edge.
REQ-020 RUN/HOLD, R=1 and ifetch_ready_i=1: next_pc=target, stall=0, flush=1; next state RUN; redirect overrides load_use_i and muldiv_busy_i.
REQ-021 RUN/HOLD, R=1 and ifetch_ready_i=0: stall=1, flush=1, next_pc=curr_pc_i; target latched into pend_pc; next state PEND.
REQ-022 RUN/HOLD, R=0 and S=1: stall=1, flush=0, next_pc=curr_pc_i; next state HOLD.
REQ-023 RUN/HOLD, R=0 and S=0: stall=0, flush=0, next_pc=curr_pc_i+4 modulo 2^CPU_WIDTH (FFFF_FFFC -> 0000_0000); next state RUN.
REQ-024 PEND, ifetch_ready_i=0: stall=1, flush=0, next_pc=pend_pc; trap_req_i=1 overwrites pend_pc with trap_vec_i (low bits cleared) and asserts flush=1; mret_req_i/ex_redir_i ignored.
REQ-025 PEND, ifetch_ready_i=1: stall=0, next_pc=pend_pc (or masked trap_vec_i if trap_req_i=1 same cycle, with flush=1), next state RUN.
REQ-026 ena_i=0 in any state: next state BOOT, outputs per BOOT; pending target discarded.
REQ-027 Redirect latency: target appears on curr_pc_i one clk edge after R sampled with ifetch_ready_i=1.

Reset
REQ-028 rst_n=0: state BOOT, pend_pc=RST_PC; outputs stall=1, flush=0, next_pc=curr_pc_i, state_o=00.
REQ-029 Reset during PEND or HOLD drops all pending redirects; no flush pulse on reset release.

Configuration
REQ-030 Macro PC_CTRL_PERF_EN defined: outputs stall_cnt_o and flush_cnt_o (32 bits each), counting cycles with pipeline_stall_o=1 outside BOOT and cycles with flush_o=1; saturate at FFFF_FFFF; reset to 0.
REQ-031 Macro PC_CTRL_PERF_EN undefined: both ports present, tied to 0, no counter flops.

Verification
REQ-032 Reset release, ena_i=1 at cycle 2, curr_pc_i=0 -> state BOOT->RUN, then next_pc_o=4, stall=0.
REQ-033 RUN, load_use_i=1 and ex_redir_i=1, ex_target_i=0x0000_0103 -> next_pc_o=0x0000_0100, flush_o=1, stall=0.
REQ-034 ex_redir_i=1 target 0x200 with ifetch_ready_i=0 for 3 cycles -> PEND, stall=1 three cycles, next_pc_o=0x200 with stall=0 on ready cycle.
REQ-035 PEND holding 0x200, trap_req_i=1 trap_vec_i=0x80 -> pend_pc=0x80, flush_o=1; on ready next_pc_o=0x80.
REQ-036 trap_req_i, mret_req_i, ex_redir_i all 1 (0x10, 0x20, 0x30) -> next_pc_o=0x10; curr_pc_i=0xFFFF_FFFC no request -> next_pc_o=0.
REQ-037 With PC_CTRL_PERF_EN, 5 load_use stall cycles and 2 redirects -> stall_cnt_o=5, flush_cnt_o=2; without macro both read 0.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - PC controller bus: pipeline requests in, next-PC/stall/flush out
interface pc_ctrl_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 ena_i;
  logic [CPU_WIDTH-1:0] curr_pc_i;
  logic                 trap_req_i;
  logic [CPU_WIDTH-1:0] trap_vec_i;
  logic                 mret_req_i;
  logic [CPU_WIDTH-1:0] mepc_i;
  logic                 ex_redir_i;
  logic [CPU_WIDTH-1:0] ex_target_i;
  logic                 load_use_i;
  logic                 muldiv_busy_i;
  logic                 ifetch_ready_i;
  logic [CPU_WIDTH-1:0] next_pc_o;
  logic                 pipeline_stall_o;
  logic                 flush_o;
  logic [1:0]           state_o;
  logic [31:0]          stall_cnt_o;
  logic [31:0]          flush_cnt_o;

  modport master (
    output ena_i, curr_pc_i, trap_req_i, trap_vec_i, mret_req_i, mepc_i,
           ex_redir_i, ex_target_i, load_use_i, muldiv_busy_i, ifetch_ready_i,
    input  next_pc_o, pipeline_stall_o, flush_o, state_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ena_i, curr_pc_i, trap_req_i, trap_vec_i, mret_req_i, mepc_i,
           ex_redir_i, ex_target_i, load_use_i, muldiv_busy_i, ifetch_ready_i,
    output next_pc_o, pipeline_stall_o, flush_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC select, stall/flush control FSM; PC_CTRL_PERF_EN adds stall/flush counters
module pc_ctrl #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RST_PC    = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_PEND = 2'b11
  } state_t;

  state_t               r_state;
  logic [CPU_WIDTH-1:0] r_pend_pc;

  logic                 w_redir;
  logic                 w_stall_src;
  logic [CPU_WIDTH-1:0] w_target_raw;
  logic [CPU_WIDTH-1:0] w_target;
  logic [CPU_WIDTH-1:0] w_trap_vec;
  logic [CPU_WIDTH-1:0] w_next_pc;
  logic                 w_stall;
  logic                 w_flush;
  logic                 w_boot;

  assign w_redir      = bus.trap_req_i | bus.mret_req_i | bus.ex_redir_i;
  assign w_stall_src  = bus.load_use_i | bus.muldiv_busy_i | ~bus.ifetch_ready_i;
  assign w_target_raw = bus.trap_req_i ? bus.trap_vec_i :
                        bus.mret_req_i ? bus.mepc_i     : bus.ex_target_i;
  assign w_target     = {w_target_raw[CPU_WIDTH-1:2], 2'b00};
  assign w_trap_vec   = {bus.trap_vec_i[CPU_WIDTH-1:2], 2'b00};
  // Disabling the core behaves like BOOT immediately, whatever state is stored
  assign w_boot       = ~bus.ena_i | (r_state == ST_BOOT);

  // Combinational next-PC / stall / flush selection by state and requests
  always_comb begin
    w_next_pc = bus.curr_pc_i;
    w_stall   = 1'b1;
    w_flush   = 1'b0;
    if (!w_boot) begin
      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (w_redir) begin
            // Redirect wins over data hazards; only a busy fetch port delays it
            w_flush = 1'b1;
            if (bus.ifetch_ready_i) begin
              w_next_pc = w_target;
              w_stall   = 1'b0;
            end
          end else if (!w_stall_src) begin
            w_next_pc = bus.curr_pc_i + CPU_WIDTH'(4);
            w_stall   = 1'b0;
          end
        end
        ST_PEND: begin
          // Only a trap may replace a parked target; mret/branch cannot arrive legitimately here
          w_next_pc = bus.trap_req_i ? w_trap_vec : r_pend_pc;
          w_flush   = bus.trap_req_i;
          w_stall   = ~bus.ifetch_ready_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.next_pc_o        = w_next_pc;
  assign bus.pipeline_stall_o = w_stall;
  assign bus.flush_o          = w_flush;
  assign bus.state_o          = r_state;

  // Controller FSM and parked-redirect register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_pend_pc <= RST_PC;
    end else if (!bus.ena_i) begin
      r_state   <= ST_BOOT;
      r_pend_pc <= RST_PC;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN, ST_HOLD: begin
          if (w_redir) begin
            if (bus.ifetch_ready_i) begin
              r_state <= ST_RUN;
            end else begin
              r_state   <= ST_PEND;
              r_pend_pc <= w_target;
            end
          end else if (w_stall_src) begin
            r_state <= ST_HOLD;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_PEND: begin
          if (bus.trap_req_i) r_pend_pc <= w_trap_vec;
          if (bus.ifetch_ready_i) r_state <= ST_RUN;
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters: stalls outside BOOT and flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !w_boot && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif

endmodule
